// File: rtl/legv8_pkg.sv
// Shared constants, state encoding and helpers for the LEGv8 instruction fetch unit.
package legv8_pkg;

    localparam logic [31:0] HALT_WORD  = 32'hFFFF_FFFF;
    localparam int          OPCODE_MSB = 31;
    localparam int          OPCODE_LSB = 22;
    localparam int          BR_OFF_W   = 19;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_WAIT   = 3'd2,
        ST_VALID  = 3'd3,
        ST_HALTED = 3'd4
    } state_t;

    function automatic logic [9:0] opcode_of(input logic [31:0] word);
        return word[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/legv8_fetch_unit_if.sv
// Instruction-memory and controller handshake bundle of the fetch unit.
interface legv8_fetch_unit_if
    import legv8_pkg::*;
#(
    parameter int PC_W = 32
) ();
    logic                imem_rd_en;
    logic [PC_W-3:0]     imem_addr;
    logic [31:0]         imem_rdata;
    logic [31:0]         instruction;
    logic [9:0]          opcode;
    logic                instr_valid;
    logic                instr_ready;
    logic                branch_taken;
    logic [BR_OFF_W-1:0] branch_offset;

    modport master (
        output imem_rd_en, imem_addr, instruction, opcode, instr_valid,
        input  imem_rdata, instr_ready, branch_taken, branch_offset
    );

    modport slave (
        input  imem_rd_en, imem_addr, instruction, opcode, instr_valid,
        output imem_rdata, instr_ready, branch_taken, branch_offset
    );
endinterface

// File: rtl/legv8_pc_next.sv
// Next-PC computation: sequential +4 or a taken branch of a signed word offset, modulo 2^PC_W.
module legv8_pc_next
    import legv8_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic [PC_W-1:0]     pc,
    input  logic                branch_taken,
    input  logic [BR_OFF_W-1:0] branch_offset,
    output logic [PC_W-1:0]     next_pc
);
    logic [PC_W-1:0] byte_offset_s;
    logic [PC_W-1:0] seq_step_s;

    // The word offset becomes a byte offset with two zero LSBs, so pc alignment is preserved.
    assign byte_offset_s = {{(PC_W-BR_OFF_W-2){branch_offset[BR_OFF_W-1]}}, branch_offset, 2'b00};
    assign seq_step_s    = {{(PC_W-3){1'b0}}, 3'b100};
    assign next_pc       = branch_taken ? (pc + byte_offset_s) : (pc + seq_step_s);
endmodule

// File: rtl/legv8_fetch_unit.sv
// LEGv8 fetch unit: fetches one word at a time, holds it for the controller, advances pc on acceptance.
module legv8_fetch_unit
    import legv8_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}},
    parameter int              COUNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    legv8_fetch_unit_if.master  bus,
    output logic [PC_W-1:0]     pc,
    output logic                halted,
    output logic [COUNT_W-1:0]  retired
);
    state_t               state_r;
    state_t               state_n_s;
    logic [PC_W-1:0]      pc_r;
    logic [PC_W-1:0]      pc_next_s;
    logic [31:0]          instr_r;
    logic [COUNT_W-1:0]   retired_r;
    logic                 rd_en_r;
    logic                 valid_r;
    logic                 halted_r;
    logic                 handshake_s;

    legv8_pc_next #(.PC_W(PC_W)) u_pc_next (
        .pc            (pc_r),
        .branch_taken  (bus.branch_taken),
        .branch_offset (bus.branch_offset),
        .next_pc       (pc_next_s)
    );

    assign handshake_s = (state_r == ST_VALID) && bus.instr_ready;

    // Next-state logic of the fetch sequencer.
    always_comb begin
        state_n_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_n_s = ST_REQ;
                else       state_n_s = ST_IDLE;
            end
            ST_REQ:  state_n_s = ST_WAIT;
            ST_WAIT: begin
                if (bus.imem_rdata == HALT_WORD) state_n_s = ST_HALTED;
                else                             state_n_s = ST_VALID;
            end
            ST_VALID: begin
                if (bus.instr_ready) state_n_s = ST_REQ;
                else                 state_n_s = ST_VALID;
            end
            ST_HALTED: state_n_s = ST_HALTED;
            default:   state_n_s = ST_IDLE;
        endcase
    end

    // State, pc, held instruction and retire counter; strobes are registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            pc_r      <= RESET_PC;
            instr_r   <= 32'h0000_0000;
            retired_r <= {COUNT_W{1'b0}};
            rd_en_r   <= 1'b0;
            valid_r   <= 1'b0;
            halted_r  <= 1'b0;
        end else begin
            state_r  <= state_n_s;
            rd_en_r  <= (state_n_s == ST_REQ);
            valid_r  <= (state_n_s == ST_VALID);
            halted_r <= (state_n_s == ST_HALTED);
            if (state_r == ST_WAIT) begin
                instr_r <= bus.imem_rdata;
            end
            if (handshake_s) begin
                pc_r <= pc_next_s;
                if (retired_r != {COUNT_W{1'b1}}) begin
                    retired_r <= retired_r + {{(COUNT_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    assign bus.imem_rd_en  = rd_en_r;
    assign bus.imem_addr   = pc_r[PC_W-1:2];
    assign bus.instruction = instr_r;
    assign bus.opcode      = opcode_of(instr_r);
    assign bus.instr_valid = valid_r;
    assign pc              = pc_r;
    assign halted          = halted_r;
    assign retired         = retired_r;
endmodule
